// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit-side FIFO controller.
//   - tx_state_e : issue FSM encoding (IDLE / WAIT_BUSY / WAIT_DONE)
//   - DATA_W_DEF / ADDR_W_DEF : default word width and FIFO address width
package uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W storage for the transmit FIFO.
// Synchronous write, combinational read by address, no reset on the array.
// Ports:
//   clk       in   write clock
//   i_we      in   write enable
//   i_waddr   in   write address
//   i_wdata   in   write data
//   i_raddr   in   read address
//   o_rdata_c out  read data (combinational)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: a same-cycle write to the read address returns the old word
    assign o_rdata_c = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: transmit-side buffer between a byte producer and a UART
// transmitter. Words pushed on dataReady are queued in a circular FIFO and
// issued one at a time with a single-cycle txStart, following txBusy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data, dataReady   word to enqueue and its push strobe
//   flush             synchronous FIFO clear (in-flight transfer continues)
//   txBusy            transmitter busy handshake
//   txStart, txData   start pulse and held word for the transmitter
//   empty/full/almostFull/level  occupancy status (registered)
//   overflow          sticky: push attempted while full
//   txTimeout         sticky busy-timeout flag (UART_TX_FIFO_TIMEOUT_EN only)
// Build option: define UART_TX_FIFO_TIMEOUT_EN to give up on a transfer when
// txBusy does not rise within BUSY_TIMEOUT cycles of txStart.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned AF_THRESH = 12
`ifdef UART_TX_FIFO_TIMEOUT_EN
    , parameter int unsigned BUSY_TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              dataReady,
    input  logic              flush,
    input  logic              txBusy,
    output logic              txStart,
    output logic [DATA_W-1:0] txData,
    output logic              empty,
    output logic              full,
    output logic              almostFull,
    output logic [ADDR_W:0]   level,
    output logic              overflow
`ifdef UART_TX_FIFO_TIMEOUT_EN
    , output logic            txTimeout
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic              w_issue;
    logic              w_push_ok;
    logic              w_ovf_evt;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [DATA_W-1:0] w_rd_data;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;

`ifdef UART_TX_FIFO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout;
    logic             w_to_evt;
`endif

    // Storage
    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_push_ok),
        .i_waddr   (r_wr_ptr),
        .i_wdata   (data),
        .i_raddr   (r_rd_ptr),
        .o_rdata_c (w_rd_data)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; w_issue pops the head and launches txStart.
    // Flush suppresses a new issue so a cleared word is never sent.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
`ifdef UART_TX_FIFO_TIMEOUT_EN
        w_to_evt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && !txBusy && !flush) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (txBusy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
`ifdef UART_TX_FIFO_TIMEOUT_EN
                else if (r_to_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_to_evt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            ST_WAIT_DONE: begin
                if (!txBusy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Push acceptance: a pop in the same cycle frees the slot of a full FIFO
    always_comb begin
        w_push_ok = dataReady && !flush && (!r_full || w_issue);
        w_ovf_evt = dataReady && !flush && r_full && !w_issue;
        if (flush) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LVL_W'(w_push_ok) - LVL_W'(w_issue);
        end
    end

    // Pointers, level and status flags (flags track the next level so they
    // always agree with the registered level)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_empty       <= (w_level_nxt == '0);
            r_full        <= (w_level_nxt == LVL_W'(DEPTH));
            r_almost_full <= (w_level_nxt >= LVL_W'(AF_THRESH));
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                end
                if (w_issue) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
                if (w_ovf_evt) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Transmitter interface: txData holds until the next issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_issue;
            if (w_issue) begin
                r_tx_data <= w_rd_data;
            end
        end
    end

`ifdef UART_TX_FIFO_TIMEOUT_EN
    // Busy-wait counter (cycles spent in WAIT_BUSY) and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_BUSY || w_state_nxt != ST_WAIT_BUSY) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_timeout <= 1'b0;
            end else if (w_to_evt) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign txTimeout = r_timeout;
`endif

    assign txStart    = r_tx_start;
    assign txData     = r_tx_data;
    assign empty      = r_empty;
    assign full       = r_full;
    assign almostFull = r_almost_full;
    assign level      = r_level;
    assign overflow   = r_overflow;

endmodule : uart_tx_fifo_ctrl
